// File: rtl/mem_arb2_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arb2_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb2_rr.sv
// Two-way round-robin picker: a lone requester wins; on contention the
// master that did not own the bus last wins.
module mem_arb2_rr
  import mem_arb2_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Select the winning requester index.
  always_comb begin
    gnt_valid = |req;
    case (req)
      2'b01:   gnt_idx = OWNER_M0;
      2'b10:   gnt_idx = OWNER_M1;
      2'b11:   gnt_idx = ~last_owner;
      default: gnt_idx = OWNER_M0;
    endcase
  end

endmodule

// File: rtl/mem_arb2.sv
// Round-robin arbiter sharing one native-bus slave between two masters.
// Optional slave-response watchdog enabled by defining MEM_ARB2_TIMEOUT_EN.
module mem_arb2
  import mem_arb2_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  input  logic                m0_instr,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  input  logic                m1_valid,
  input  logic                m1_instr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                s_valid,
  output logic                s_instr,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant
`ifdef MEM_ARB2_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  state_t state_r;
  logic   owner_r;
  logic   last_owner_r;
  logic   gnt_valid_s;
  logic   gnt_idx_s;
  logic   busy_s;
  logic   to_hit_s;
  logic   done_s;

  mem_arb2_rr u_rr (
    .req        ({m1_valid, m0_valid}),
    .last_owner (last_owner_r),
    .gnt_valid  (gnt_valid_s),
    .gnt_idx    (gnt_idx_s)
  );

  assign busy_s = (state_r == BUSY);
  assign done_s = busy_s && (s_ready || to_hit_s);

`ifdef MEM_ARB2_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] cnt_r;

  // The arbiter completes the transaction itself only when the slave stays silent.
  assign to_hit_s = busy_s && !s_ready && (cnt_r == CNT_W'(TIMEOUT_CYCLES));

  // Count BUSY cycles without a slave response; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      timeout_err <= 1'b0;
    end else begin
      if (!busy_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (!s_ready && !to_hit_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (to_hit_s) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign to_hit_s = 1'b0;
`endif

  // Transaction FSM: latch the winner's request, hold it until completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      owner_r      <= OWNER_M0;
      last_owner_r <= OWNER_M1;
      s_valid      <= 1'b0;
      s_instr      <= 1'b0;
      s_addr       <= {ADDR_W{1'b0}};
      s_wdata      <= {DATA_W{1'b0}};
      s_wstrb      <= {(DATA_W/8){1'b0}};
      grant        <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            state_r <= BUSY;
            owner_r <= gnt_idx_s;
            s_valid <= 1'b1;
            if (gnt_idx_s == OWNER_M1) begin
              grant   <= 2'b10;
              s_instr <= m1_instr;
              s_addr  <= m1_addr;
              s_wdata <= m1_wdata;
              s_wstrb <= m1_wstrb;
            end else begin
              grant   <= 2'b01;
              s_instr <= m0_instr;
              s_addr  <= m0_addr;
              s_wdata <= m0_wdata;
              s_wstrb <= m0_wstrb;
            end
          end
        end
        BUSY: begin
          if (done_s) begin
            state_r      <= IDLE;
            s_valid      <= 1'b0;
            grant        <= 2'b00;
            last_owner_r <= owner_r;
          end
        end
        default: begin
          state_r <= IDLE;
          s_valid <= 1'b0;
          grant   <= 2'b00;
        end
      endcase
    end
  end

  // Completion pulse to the owner only; read data is a straight broadcast.
  always_comb begin
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    if (done_s) begin
      if (owner_r == OWNER_M1) begin
        m1_ready = 1'b1;
      end else begin
        m0_ready = 1'b1;
      end
    end else begin
      m0_ready = 1'b0;
      m1_ready = 1'b0;
    end
    if (to_hit_s) begin
      m_rdata = DATA_W'(TIMEOUT_RDATA);
    end else begin
      m_rdata = s_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Scoreboard bench for mem_arb2: masters push expected requests, a negedge
// monitor applies the arbitration rules and checks everything the DUT drives.
module tb_mem_arb2;

  localparam int TO = 8;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 1'b0, m0_instr = 1'b0, m0_ready;
  logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
  logic [3:0]  m0_wstrb = 4'h0;
  logic        m1_valid = 1'b0, m1_instr = 1'b0, m1_ready;
  logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
  logic [3:0]  m1_wstrb = 4'h0;
  logic [31:0] m_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
`ifdef MEM_ARB2_TIMEOUT_EN
  logic        timeout_err;
`endif

  mem_arb2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready),
    .m_rdata(m_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant)
`ifdef MEM_ARB2_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues and slave-model controls
  req_t        q0[$], q1[$];
  logic [1:0]  grant_log[$];
  logic [31:0] last_rdata0 = 32'h0;
  bit          slave_stall = 1'b0, spur_en = 1'b0, fixed_rd_en = 1'b0;
  int          fixed_lat = -1;
  logic [31:0] fixed_rd = 32'h0;

  // Slave model: random or fixed latency, optional stray s_ready while idle
  initial begin
    int lat;
    lat = 0;
    s_ready = 1'b0;
    s_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (s_ready) begin
        s_ready = 1'b0;
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3, 0));
      end else if (s_valid) begin
        if (!slave_stall) begin
          if (lat <= 0) begin
            s_ready = 1'b1;
            s_rdata = fixed_rd_en ? fixed_rd : $urandom;
          end else begin
            lat--;
          end
        end
      end else begin
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3, 0));
        s_ready = spur_en && ($urandom_range(7, 0) == 0);
        s_rdata = $urandom;
      end
    end
  end

  // Reference model state, advanced by the monitor
  bit         cur_active = 1'b0;
  req_t       cur;
  logic       cur_owner = 1'b0;
  logic       last = 1'b1;
  int         busy_n = 0;
  bit         exp_rise = 1'b0, exp_idle = 1'b0;
  logic [1:0] prev_valid = 2'b00;

  // Monitor: arbitration rules, latency, hold stability, ready and rdata routing
  always @(negedge clk) begin
    logic done, tohit, exp0, exp1;
    logic [31:0] exp_rd;
    if (reset) begin
      cur_active = 1'b0;
      last = 1'b1;
      exp_rise = 1'b0;
      exp_idle = 1'b0;
      q0.delete();
      q1.delete();
    end else begin
      if (exp_rise) chk("grant_latency", s_valid, 1);
      if (exp_idle) begin
        chk("dead_cycle_svalid", s_valid, 0);
        chk("dead_cycle_grant", grant, 0);
      end
      if (s_valid && !cur_active && !exp_idle) begin
        chk("grant_had_request", prev_valid != 2'b00, 1);
        cur_owner = (prev_valid == 2'b10) ? 1'b1 : (prev_valid == 2'b11) ? ~last : 1'b0;
        chk("grant_owner", grant, cur_owner ? 2'b10 : 2'b01);
        grant_log.push_back(grant);
        if ((cur_owner ? q1.size() : q0.size()) == 0) begin
          chk("queue_nonempty", 0, 1);
        end else begin
          cur = cur_owner ? q1.pop_front() : q0.pop_front();
          cur_active = 1'b1;
          busy_n = 0;
        end
      end
      done = 1'b0; tohit = 1'b0; exp0 = 1'b0; exp1 = 1'b0;
      if (cur_active) begin
        busy_n++;
        chk("busy_svalid", s_valid, 1);
        chk("busy_grant", grant, cur_owner ? 2'b10 : 2'b01);
        chk("hold_instr", s_instr, cur.instr);
        chk("hold_addr", s_addr, cur.addr);
        chk("hold_wdata", s_wdata, cur.wdata);
        chk("hold_wstrb", s_wstrb, cur.wstrb);
`ifdef MEM_ARB2_TIMEOUT_EN
        tohit = !s_ready && (busy_n == TO + 1);
`endif
        done = s_ready || tohit;
        exp0 = done && !cur_owner;
        exp1 = done && cur_owner;
      end
      exp_rd = tohit ? 32'hDEADBEEF : s_rdata;
      chk("m0_ready", m0_ready, exp0);
      chk("m1_ready", m1_ready, exp1);
      chk("m_rdata", m_rdata, exp_rd);
      if (m0_ready) last_rdata0 = m_rdata;
      exp_idle = done;
      if (done) begin
        last = cur_owner;
        cur_active = 1'b0;
      end
      exp_rise = !s_valid && (m0_valid || m1_valid);
    end
    prev_valid = {m1_valid, m0_valid};
  end

  // One whole master transaction: raise, optionally disturb while owned, wait, drop
  task automatic m_txn(input int i, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input bit scramble);
    req_t r;
    bit   got;
    int   n;
    r = '{instr: instr, addr: addr, wdata: wdata, wstrb: wstrb};
    @(posedge clk); #1;
    if (i == 0) begin
      q0.push_back(r);
      m0_valid = 1'b1; m0_instr = instr; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end else begin
      q1.push_back(r);
      m1_valid = 1'b1; m1_instr = instr; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = (i == 0) ? m0_ready : m1_ready;
      if (!got && scramble && s_valid && grant[i]) begin
        if (i == 0) begin
          m0_addr = 32'h0; m0_wstrb = 4'hF; m0_wdata = $urandom; m0_instr = ~instr;
        end else begin
          m1_addr = 32'h0; m1_wstrb = 4'hF; m1_wdata = $urandom; m1_instr = ~instr;
        end
      end
      n++;
    end
    if (!got) chk("ready_wait_bound", 0, 1);
    @(posedge clk); #1;
    if (i == 0) m0_valid = 1'b0;
    else        m1_valid = 1'b0;
  endtask

  task automatic rand_master(input int i, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(3, 0)) @(posedge clk);
      m_txn(i, 1'($urandom_range(1, 0)), $urandom, $urandom, 4'($urandom_range(15, 0)),
            ($urandom_range(3, 0) == 0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] fair_exp [6];
    fair_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_instr", s_instr, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_s_wstrb", s_wstrb, 0);
    chk("rst_grant", grant, 0);
`ifdef MEM_ARB2_TIMEOUT_EN
    chk("rst_timeout_err", timeout_err, 0);
`endif
    @(posedge clk); #1 reset = 1'b0;

    // Contention straight after reset: m0 then m1
    grant_log.delete();
    fork
      m_txn(0, 1'b1, 32'h0000_1000, 32'h0, 4'h0, 1'b0);
      m_txn(1, 1'b0, 32'h0000_2000, 32'hCAFE_0001, 4'h3, 1'b0);
    join
    chk("contention_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("contention_first", grant_log[0], 2'b01);
      chk("contention_second", grant_log[1], 2'b10);
    end

    // Fairness: both masters keep requesting
    grant_log.delete();
    fork
      repeat (3) m_txn(0, 1'b0, 32'h0000_0010, 32'h1111_1111, 4'hF, 1'b0);
      repeat (3) m_txn(1, 1'b0, 32'h0000_0020, 32'h2222_2222, 4'h1, 1'b0);
    join
    chk("fair_count", grant_log.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < grant_log.size()) chk("fair_seq", grant_log[k], fair_exp[k]);
    end

    // Single m0 read with a 1-cycle slave
    fixed_lat = 1; fixed_rd_en = 1'b1; fixed_rd = 32'h1234_5678;
    m_txn(0, 1'b0, 32'h0000_03FC, 32'h0, 4'h0, 1'b0);
    chk("single_rdata", last_rdata0, 32'h1234_5678);

    // Stability: m0 disturbs its inputs while owning a slow transaction
    fixed_lat = 4; fixed_rd_en = 1'b0;
    m_txn(0, 1'b0, 32'h0000_03FC, 32'h0, 4'h0, 1'b1);

    // Reset in the middle of a stalled transaction
    slave_stall = 1'b1;
    @(posedge clk); #1;
    q0.push_back('{instr: 1'b0, addr: 32'h100, wdata: 32'h0, wstrb: 4'h0});
    m0_valid = 1'b1; m0_instr = 1'b0; m0_addr = 32'h100; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_mid_busy", s_valid, 1);
    @(posedge clk); #1 reset = 1'b1; m0_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_svalid", s_valid, 0);
    chk("rst_mid_grant", grant, 0);
    chk("rst_mid_ready", m0_ready, 0);
    slave_stall = 1'b0; fixed_lat = -1;

    grant_log.delete();
    fork
      m_txn(1, 1'b1, 32'h0000_3000, 32'h0, 4'h0, 1'b0);
      m_txn(0, 1'b0, 32'h0000_4000, 32'h5555_AAAA, 4'hC, 1'b0);
    join
    if (grant_log.size() > 0) chk("post_rst_first", grant_log[0], 2'b01);
    else chk("post_rst_count", grant_log.size(), 2);

    // Randomised traffic with stray slave readies
    spur_en = 1'b1;
    fork
      rand_master(0, 15);
      rand_master(1, 15);
    join
    spur_en = 1'b0;

`ifdef MEM_ARB2_TIMEOUT_EN
    // Silent slave: watchdog completes the transaction
    slave_stall = 1'b1;
    m_txn(0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b0);
    chk("timeout_rdata", last_rdata0, 32'hDEADBEEF);
    chk("timeout_err_set", timeout_err, 1);
    repeat (5) @(negedge clk);
    chk("timeout_err_sticky", timeout_err, 1);
    slave_stall = 1'b0;
`endif

    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb2.md
Name: mem_arb2

Overview:
- Two-requester arbiter for the native CPU memory bus (valid/ready, addr, wdata, wstrb, rdata, instr).
- Shares one memory/peripheral slave between master 0 (CPU core) and master 1 (DMA or debug loader).
- Grants one whole transaction at a time, using round-robin.
- Latches the granted request so the slave sees stable signals until it returns ready.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 255, cycle limit for slave response. Used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m0_valid  in  1  master 0 request
- m0_instr  in  1  master 0 instruction fetch flag
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_wstrb  in  DATA_W/8  master 0 byte strobes; 0 means read
- m0_ready  out  1  master 0 completion pulse
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready: same as m0_*, for master 1
- m_rdata  out  DATA_W  read data, broadcast to both masters
- s_valid  out  1  slave request
- s_instr  out  1  slave instruction fetch flag
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_wstrb  out  DATA_W/8  slave byte strobes
- s_ready  in  1  slave completion
- s_rdata  in  DATA_W  slave read data
- grant  out  2  one-hot owner of current transaction, for debug

Behaviour:
- Clock and reset:
  - One clock domain.
  - reset is sampled on the rising edge of clk and is active-high.
- Reset values:
  - state=IDLE, s_valid=0, s_instr=0.
  - s_addr, s_wdata and s_wstrb are 0.
  - grant=00, last_owner=1, so master 0 wins the first contention.
- States: IDLE, BUSY.
- IDLE:
  - If neither m0_valid nor m1_valid is set, stay in IDLE.
  - If exactly one is set, grant that master.
  - If both are set, grant the master that is not last_owner.
  - On grant, at the next edge: latch that master's instr/addr/wdata/wstrb into s_*, set s_valid=1, set grant, go to BUSY.
  - Latency is 1 cycle from m_valid to s_valid.
- BUSY:
  - s_* are held stable. Changes on the masters' inputs are ignored.
  - m<owner>_ready = s_ready, combinationally. The other master's ready stays 0.
  - m_rdata = s_rdata, combinationally, at all times.
  - On s_valid && s_ready: at the next edge s_valid=0, grant=00, last_owner=owner, go to IDLE.
- One dead cycle in IDLE between transactions is required.
  - The completing master has dropped its valid by then, so it cannot be re-granted falsely.
- Starvation bound:
  - A continuously requesting master waits at most one foreign transaction.
- Owner drops valid mid-transaction (protocol violation):
  - The transaction still completes on the slave.
  - The ready pulse is still driven to the owner.
  - No abort.
- Simultaneous events:
  - A new request arriving in the same cycle as s_ready is not seen until IDLE.
  - s_ready while in IDLE is ignored; no m_ready is generated.
- Reset mid-transaction:
  - Abandons the transaction immediately. s_valid=0 at the next edge.
  - No m_ready is issued.
- The block does no address decode and no width conversion.

Optional Feature:
- Macro: MEM_ARB2_TIMEOUT_EN.
- Defined:
  - An 8–16 bit counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When the count reaches TIMEOUT_CYCLES, the arbiter completes the transaction itself:
    - m<owner>_ready=1 for 1 cycle.
    - m_rdata=32'hDEADBEEF for that cycle.
    - s_valid drops and the state returns to IDLE.
    - Sticky output timeout_err (1 bit, reset 0) is set; only reset clears it.
  - A late s_ready after a timeout, seen in IDLE, is ignored.
- Not defined:
  - No counter, and no timeout_err port.
  - BUSY waits indefinitely for s_ready.

Decomposition:
- Package mem_arb2_pkg holds:
  - state enum {IDLE, BUSY};
  - owner constants OWNER_M0=0, OWNER_M1=1;
  - TIMEOUT_RDATA=32'hDEADBEEF.
- Sub-module mem_arb2_rr: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: gnt_valid, gnt_idx.

Test Plan:
- Single master: m0 reads 0x3FC; the slave model returns ready 1 cycle after s_valid with rdata 0x12345678.
  - Required: s_valid rises 1 cycle after m0_valid; m0_ready pulses once with m_rdata=0x12345678; m1_ready stays 0.
- Contention after reset: m0 and m1 assert valid in the same cycle.
  - Required: m0 granted first (grant=01), then m1 (grant=10).
  - Required: 1 IDLE cycle between the two transactions.
- Fairness: both masters hold requests for 6 transactions.
  - Required: grant sequence 01,10,01,10,01,10.
- Stability: during BUSY, m0 changes addr from 0x3FC to 0x000 and wstrb to 4'b1111.
  - Required: s_addr stays 0x3FC and s_wstrb stays 0 until s_ready.
- Reset mid-operation: assert reset in BUSY while the slave withholds ready.
  - Required: s_valid=0 and grant=00 next cycle; no m_ready pulse.
  - Required: the next contention grants m0.
- With MEM_ARB2_TIMEOUT_EN and TIMEOUT_CYCLES=8: the slave never responds.
  - Required: m0_ready pulses after 8 BUSY cycles with m_rdata=0xDEADBEEF; timeout_err=1 and stays 1.
